// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, memory strobes and multiplier start.
module multicycle_ctrl_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit MUL_EN      = 1'b1,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       funct7_0,
  input  logic       mem_ready,
  input  logic       mul_done,
  output logic       pc_write_cond,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       mul_start,
  output logic       is_ecall,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_JUMP     = 4'd11,
    S_MUL_WAIT = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  state_t state, state_next;
  logic   ready;
  logic   mul_busy;
  logic   illegal_q;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // mul_busy marks every MUL_WAIT cycle after the first, so the start pulse is one cycle wide
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      mul_busy  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      mul_busy  <= (state == S_MUL_WAIT);
      illegal_q <= illegal_q | (state_next == S_ILLEGAL);
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_OP:             state_next = (MUL_EN && funct7_0) ? S_MUL_WAIT : S_EXEC_R;
          OP_IMM:            state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL, OP_JALR:   state_next = S_JUMP;
          OP_SYSTEM:         state_next = S_HALT;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_next = ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_next = ready ? S_FETCH : S_MEM_WR;
      S_MEM_WB:   state_next = S_FETCH;
      S_EXEC_R:   state_next = S_R_WB;
      S_EXEC_I:   state_next = S_R_WB;
      S_R_WB:     state_next = S_FETCH;
      S_MUL_WAIT: state_next = mul_done ? S_R_WB : S_MUL_WAIT;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_HALT:     state_next = HALT_STICKY ? S_HALT : S_FETCH;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_cond = 1'b0;
    pc_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_b     = 2'b00;
    mul_start     = 1'b0;
    is_ecall      = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = ready;
          ir_write  = ready;
        end
        S_DECODE:   alu_src_b = 2'b10;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          wb_sel    = 2'b01;
        end
        S_EXEC_R, S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = (state == S_EXEC_I) ? 2'b10 : 2'b00;
          alu_op    = 2'b10;
        end
        S_R_WB:     reg_write = 1'b1;
        S_MUL_WAIT: mul_start = ~mul_busy;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          alu_src_b = 2'b10;
          alu_src_a = (opcode == OP_JALR);
          pc_write  = 1'b1;
          reg_write = 1'b1;
          wb_sel    = 2'b10;
        end
        S_HALT:     is_ecall = 1'b1;
        default:    ;
      endcase
    end
  end

  assign illegal = illegal_q & ~reset;
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: expected per-cycle state/output trace is built per
// instruction from its class and randomized wait lengths, then replayed against the DUT.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       funct7_0 = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mul_done = 1'b0;
  logic       pc_write_cond, pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic       alu_src_a, reg_write, mul_start, is_ecall, illegal;
  logic [1:0] wb_sel, pc_source, alu_op, alu_src_b;
  logic [3:0] state_o;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct7_0(funct7_0),
    .mem_ready(mem_ready), .mul_done(mul_done),
    .pc_write_cond(pc_write_cond), .pc_write(pc_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .alu_src_a(alu_src_a), .reg_write(reg_write), .wb_sel(wb_sel),
    .pc_source(pc_source), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .mul_start(mul_start), .is_ecall(is_ecall), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011,
                         OPIMM = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, SYS = 7'b1110011, BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] op;
    logic       f7;
    logic       mr;
    logic       md;
    logic       ms;
  } cyc_t;

  cyc_t plan[$];
  int checks = 0;
  int errors = 0;

  wire [20:0] outs = {pc_write_cond, pc_write, i_or_d, mem_read, mem_write, ir_write,
                      alu_src_a, reg_write, wb_sel, pc_source, alu_op, alu_src_b,
                      mul_start, is_ecall, illegal};

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Output table per state, as listed in the control-signal description
  function automatic logic [20:0] expect_outs(logic [3:0] st, logic [6:0] op, logic mr, logic ms);
    logic pwc, pw, iod, mrd, mwr, irw, asa, rw, mst, ec, il;
    logic [1:0] wb, pcs, aop, asb;
    {pwc, pw, iod, mrd, mwr, irw, asa, rw, mst, ec, il} = '0;
    {wb, pcs, aop, asb} = '0;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
      4'd1:  asb = 2'b10;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; wb = 2'b01; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  rw = 1;
      4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      4'd9:  ec = 1;
      4'd10: begin asa = 1; asb = 2'b10; aop = 2'b10; end
      4'd11: begin asb = 2'b10; asa = (op == JALR); pw = 1; rw = 1; wb = 2'b10; end
      4'd12: mst = ms;
      4'd13: il = 1;
      default: ;
    endcase
    return {pwc, pw, iod, mrd, mwr, irw, asa, rw, wb, pcs, aop, asb, mst, ec, il};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [3:0] st, logic [6:0] op, logic f7, logic mr, logic md, logic ms);
    cyc_t c;
    c.st = st; c.op = op; c.f7 = f7; c.mr = mr; c.md = md; c.ms = ms;
    plan.push_back(c);
  endtask

  // kind: 0 LOAD 1 STORE 2 ADD 3 MUL 4 OPIMM 5 BRANCH 6 JAL 7 JALR 8 SYSTEM 9 unknown
  task automatic plan_instr(int kind, int fw, int mw, int uw, int hold);
    logic [6:0] op;
    logic f7;
    case (kind)
      0: op = LOAD;  1: op = STORE; 2, 3: op = OP; 4: op = OPIMM;
      5: op = BR;    6: op = JAL;   7: op = JALR; 8: op = SYS;
      default: op = BAD;
    endcase
    f7 = (kind == 3) ? 1'b1 : (kind == 2) ? 1'b0 : rnd();
    for (int i = 0; i < fw; i++) push(4'd0, op, f7, 1'b0, rnd(), 1'b0);
    push(4'd0, op, f7, 1'b1, rnd(), 1'b0);
    push(4'd1, op, f7, rnd(), rnd(), 1'b0);
    case (kind)
      0: begin
        push(4'd2, op, f7, rnd(), rnd(), 1'b0);
        for (int i = 0; i < mw; i++) push(4'd3, op, f7, 1'b0, rnd(), 1'b0);
        push(4'd3, op, f7, 1'b1, rnd(), 1'b0);
        push(4'd4, op, f7, rnd(), rnd(), 1'b0);
      end
      1: begin
        push(4'd2, op, f7, rnd(), rnd(), 1'b0);
        for (int i = 0; i < mw; i++) push(4'd5, op, f7, 1'b0, rnd(), 1'b0);
        push(4'd5, op, f7, 1'b1, rnd(), 1'b0);
      end
      2: begin push(4'd6, op, f7, rnd(), rnd(), 1'b0); push(4'd7, op, f7, rnd(), rnd(), 1'b0); end
      3: begin
        for (int i = 0; i < uw; i++) push(4'd12, op, f7, rnd(), 1'b0, i == 0);
        push(4'd12, op, f7, rnd(), 1'b1, uw == 0);
        push(4'd7, op, f7, rnd(), rnd(), 1'b0);
      end
      4: begin push(4'd10, op, f7, rnd(), rnd(), 1'b0); push(4'd7, op, f7, rnd(), rnd(), 1'b0); end
      5: push(4'd8, op, f7, rnd(), rnd(), 1'b0);
      6, 7: push(4'd11, op, f7, rnd(), rnd(), 1'b0);
      8: for (int i = 0; i < hold; i++) push(4'd9, op, f7, rnd(), rnd(), 1'b0);
      default: for (int i = 0; i < hold; i++) push(4'd13, op, f7, rnd(), rnd(), 1'b0);
    endcase
  endtask

  task automatic run_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge clk);
      opcode = c.op; funct7_0 = c.f7; mem_ready = c.mr; mul_done = c.md;
      #1;
      check("state", 32'(state_o), 32'(c.st));
      check("outs", 32'(outs), 32'(expect_outs(c.st, c.op, c.mr, c.ms)));
    end
  endtask

  // Assert reset for one edge: outputs forced low immediately, FETCH after the edge
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = rnd(); mul_done = rnd();
    #1;
    check("rst_outs_async_view", 32'(outs), 32'd0);
    @(negedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_outs", 32'(outs), 32'd0);
    mem_ready = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    plan_instr(2, 0, 0, 0, 0);  run_plan();
    plan_instr(0, 0, 3, 0, 0);  run_plan();
    plan_instr(3, 0, 0, 5, 0);  run_plan();
    plan_instr(7, 1, 0, 0, 0);  run_plan();
    plan_instr(6, 2, 0, 0, 0);  run_plan();
    for (int n = 0; n < 150; n++) begin
      plan_instr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 4),
                 $urandom_range(0, 6), 0);
      run_plan();
    end
    plan_instr(8, 0, 0, 0, 12); run_plan();
    do_reset();

    // reset in the middle of a multiply wait
    push(4'd0, OP, 1'b1, 1'b1, 1'b0, 1'b0);
    push(4'd1, OP, 1'b1, 1'b0, 1'b0, 1'b0);
    push(4'd12, OP, 1'b1, 1'b0, 1'b0, 1'b1);
    push(4'd12, OP, 1'b1, 1'b1, 1'b0, 1'b0);
    run_plan();
    mul_done = 1'b0;
    do_reset();
    check("post_rst_mul_start", 32'(mul_start), 32'd0);
    plan_instr(3, 0, 0, 2, 0);  run_plan();

    // reset in the middle of a load wait
    push(4'd0, LOAD, 1'b0, 1'b1, 1'b0, 1'b0);
    push(4'd1, LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    push(4'd2, LOAD, 1'b0, 1'b1, 1'b0, 1'b0);
    push(4'd3, LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    run_plan();
    do_reset();

    plan_instr(9, 1, 0, 0, 8);  run_plan();
    do_reset();
    plan_instr(2, 0, 0, 0, 0);  run_plan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
